mips_mc_control: RTL

Main controller FSM for the MIPS multi-cycle datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives every 2-input and 4-input datapath mux select (IorD, ALUSrcA, RegDst, MemtoReg, ALUSrcB, PCSrc), all architectural write enables and the ALU control code. It sits directly upstream of the datapath muxes and consumes the opcode/funct fields of the instruction register plus the ALU zero flag.

---
 rtl/mips_mc_control_if.sv | 36 +++
 rtl/mips_mc_control.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control_if.sv
// Control/datapath boundary of the MIPS multi-cycle core: instruction fields and
// status flow into the controller, mux selects and write enables flow out.
interface mips_mc_control_if;
    // Handshake: mem_ready is a valid/ready style completion flag. A memory access
    // finishes in the cycle it is high. While it is low, the controller holds its
    // current access state and keeps that state's strobes (IRWrite/PCEn excepted)
    // asserted.
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic       illegal_op;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, ALUControl, PCSrc, PCEn, illegal_op
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, ALUControl, PCSrc, PCEn, illegal_op
    );
endinterface

// File: rtl/mips_mc_control.sv
// Main controller FSM of the MIPS multi-cycle datapath.
// Optional bne support is built when MIPS_MC_BNE_EN is defined.
module mips_mc_control #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic               clk,
    input  logic               rst_n,
    mips_mc_control_if.master  bus,
    output logic [3:0]         dbg_state
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     state;
    logic       is_lw;
    logic       op_ok;
    logic       funct_ok;
    logic [2:0] funct_alu;
    logic       pc_write;
    logic       branch;
    logic       taken;

    assign dbg_state = state;

    always_comb begin
        op_ok = 1'b1;
        case (bus.opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_ok = 1'b1;
`ifdef MIPS_MC_BNE_EN
            OP_BNE:                                        op_ok = 1'b1;
`endif
            default:                                       op_ok = 1'b0;
        endcase
    end

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (bus.funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

`ifdef MIPS_MC_BNE_EN
    logic is_bne;
    assign taken = is_bne ? ~bus.zero : bus.zero;
`else
    assign taken = bus.zero;
`endif

    // lw/sw is remembered at DECODE so later IR changes cannot redirect MEMADR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= state_t'(RESET_STATE);
            is_lw <= 1'b0;
`ifdef MIPS_MC_BNE_EN
            is_bne <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH:    if (bus.mem_ready) state <= DECODE;
                DECODE: begin
                    is_lw <= (bus.opcode == OP_LW);
                    case (bus.opcode)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_RTYPE:     state <= EXECUTE;
                        OP_BEQ:       state <= BRANCH;
`ifdef MIPS_MC_BNE_EN
                        OP_BNE: begin
                            state  <= BRANCH;
                            is_bne <= 1'b1;
                        end
`endif
                        OP_ADDI:      state <= ADDIEXEC;
                        OP_J:         state <= JUMP;
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR:   state <= is_lw ? MEMRD : MEMWR;
                MEMRD:    if (bus.mem_ready) state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWR:    if (bus.mem_ready) state <= FETCH;
                EXECUTE:  state <= ALUWB;
                ALUWB:    state <= FETCH;
                BRANCH: begin
                    state <= FETCH;
`ifdef MIPS_MC_BNE_EN
                    is_bne <= 1'b0;
`endif
                end
                ADDIEXEC: state <= ADDIWB;
                ADDIWB:   state <= FETCH;
                JUMP:     state <= FETCH;
                default:  state <= FETCH;
            endcase
        end
    end

    always_comb begin
        bus.IorD       = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegDst     = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.ALUControl = ALU_ADD;
        bus.PCSrc      = 2'b00;
        bus.illegal_op = 1'b0;
        pc_write       = 1'b0;
        branch         = 1'b0;
        case (state)
            FETCH: begin
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.mem_ready;
                pc_write    = bus.mem_ready;
            end
            DECODE: begin
                bus.ALUSrcB    = 2'b11;
                bus.illegal_op = ~op_ok;
            end
            MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            MEMRD:    bus.IorD = 1'b1;
            MEMWB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
            end
            MEMWR: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
            end
            EXECUTE: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = funct_alu;
                bus.illegal_op = ~funct_ok;
            end
            ALUWB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = ALU_SUB;
                bus.PCSrc      = 2'b01;
                branch         = 1'b1;
            end
            ADDIEXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            ADDIWB:   bus.RegWrite = 1'b1;
            JUMP: begin
                bus.PCSrc = 2'b10;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
        bus.PCEn = pc_write | (branch & taken);
        // Held reset must mask mem_ready-driven strobes too, not just the state.
        if (!rst_n) begin
            bus.IorD       = 1'b0;
            bus.MemWrite   = 1'b0;
            bus.IRWrite    = 1'b0;
            bus.RegDst     = 1'b0;
            bus.MemtoReg   = 1'b0;
            bus.RegWrite   = 1'b0;
            bus.ALUSrcA    = 1'b0;
            bus.ALUSrcB    = 2'b00;
            bus.ALUControl = ALU_ADD;
            bus.PCSrc      = 2'b00;
            bus.PCEn       = 1'b0;
            bus.illegal_op = 1'b0;
        end
    end
endmodule
